// File: rtl/p32_mem_access_if.sv
// Data-memory bus between p32_mem_access (master) and the memory responder (slave).
// req/ack handshake with wait states; read data is valid in the ack cycle.
interface p32_mem_access_if #(
    parameter int unsigned ADDR_W = 30
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/p32_mem_access.sv
// Load/store responder: one data-memory transaction per execute-stage request, load result extended.
// Optional request timeout/abort is enabled by defining P32_MEM_TIMEOUT_EN.
module p32_mem_access #(
    parameter int unsigned ADDR_W  = 30,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        m_clock,
    input  logic        p_reset,
    input  logic        exec,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] mdata,
    input  logic [3:0]  store_loc,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        err,
    p32_mem_access_if.master mem
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    logic [1:0]        state;
    logic [3:0]        op_q;
    logic [1:0]        lane_q;
    logic              mis_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;

    logic              op_valid;
    logic              op_misal;
    logic [31:0]       shifted;
    logic [31:0]       load_val;

    // op[1:0] encodes size (00 byte, 01 half, 11 word), op[2] unsigned, op[3] store
    always_comb begin
        op_valid = 1'b0;
        case (op)
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B: op_valid = 1'b1;
            default: op_valid = 1'b0;
        endcase
        op_misal = ((op[1:0] == 2'b11) && (addr[1:0] != 2'b00)) ||
                   ((op[1:0] == 2'b01) && addr[0]);
    end

    always_comb begin
        shifted  = mem.mem_rdata >> {lane_q, 3'b000};
        load_val = mem.mem_rdata;
        case (op_q[1:0])
            2'b00:   load_val = op_q[2] ? {24'h000000, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = op_q[2] ? {16'h0000, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = mem.mem_rdata;
        endcase
    end

`ifdef P32_MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] tcnt;
    logic       tmo_q;
`else
    localparam int unsigned timeout_unused = TIMEOUT;
`endif

    always_ff @(posedge m_clock) begin
        if (!p_reset) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            lane_q  <= '0;
            mis_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef P32_MEM_TIMEOUT_EN
            tcnt    <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (exec && op_valid) begin
                        op_q    <= op[3:0];
                        lane_q  <= addr[1:0];
                        addr_q  <= addr[ADDR_W+1:2];
                        we_q    <= op[3];
                        be_q    <= op[3] ? store_loc : '1;
                        wdata_q <= mdata;
`ifdef P32_MEM_TIMEOUT_EN
                        tcnt    <= '0;
                        tmo_q   <= 1'b0;
`endif
                        if (op_misal) begin
                            state   <= ST_FAULT;
                            mis_q   <= 1'b1;
                            rdata_q <= '0;
                        end else if (op[3] && (store_loc == 4'b0000)) begin
                            state <= ST_FAULT;
                            mis_q <= 1'b0;
                        end else begin
                            state <= ST_REQ;
                            mis_q <= 1'b0;
                        end
                    end
                end
                ST_REQ: begin
                    // an ack always wins over a timeout reached in the same cycle
                    if (mem.mem_ack) begin
                        if (!op_q[3]) begin
                            rdata_q <= load_val;
                        end
                        state <= ST_DONE;
                    end
`ifdef P32_MEM_TIMEOUT_EN
                    else if (tcnt == TMO_LAST) begin
                        tmo_q <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
`endif
                end
                ST_DONE:  state <= ST_IDLE;
                ST_FAULT: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE) || (state == ST_FAULT);
    assign misalign = (state == ST_FAULT) && mis_q;
    assign rdata    = rdata_q;

`ifdef P32_MEM_TIMEOUT_EN
    assign err = (state == ST_DONE) && tmo_q;
`else
    assign err = 1'b0;
`endif

    assign mem.mem_req   = (state == ST_REQ);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_p32_mem_access.sv
// Directed plus randomized bench for p32_mem_access with a transaction-level reference model.
// Timeout section adapts to whether P32_MEM_TIMEOUT_EN is defined (built with TIMEOUT=4).
module tb_p32_mem_access;

    localparam int unsigned AW = 30;

    logic        m_clock = 1'b0;
    logic        p_reset = 1'b0;
    logic        exec = 1'b0;
    logic [5:0]  op = '0;
    logic [31:0] addr = '0;
    logic [31:0] mdata = '0;
    logic [3:0]  store_loc = '0;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        misalign;
    logic        err;

    p32_mem_access_if #(.ADDR_W(AW)) bus ();

    p32_mem_access #(.ADDR_W(AW), .TIMEOUT(4)) dut (
        .m_clock   (m_clock),
        .p_reset   (p_reset),
        .exec      (exec),
        .op        (op),
        .addr      (addr),
        .mdata     (mdata),
        .store_loc (store_loc),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .misalign  (misalign),
        .err       (err),
        .mem       (bus.master)
    );

    always #5 m_clock = ~m_clock;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_rdata = '0;

    task automatic tick();
        @(posedge m_clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_valid(input logic [5:0] o);
        return (o == 6'h20) || (o == 6'h21) || (o == 6'h23) || (o == 6'h24) ||
               (o == 6'h25) || (o == 6'h28) || (o == 6'h29) || (o == 6'h2B);
    endfunction

    function automatic bit is_store(input logic [5:0] o);
        return (o == 6'h28) || (o == 6'h29) || (o == 6'h2B);
    endfunction

    function automatic int unsigned size_of(input logic [5:0] o);
        if (o == 6'h20 || o == 6'h24 || o == 6'h28) return 1;
        if (o == 6'h21 || o == 6'h25 || o == 6'h29) return 2;
        return 4;
    endfunction

    // extract the addressed bytes arithmetically and extend by opcode
    function automatic logic [31:0] ref_load(input logic [5:0] o, input logic [31:0] a,
                                             input logic [31:0] d);
        longint v;
        longint part;
        v = longint'(d) / (longint'(1) << (8 * (a % 4)));
        case (size_of(o))
            1: begin
                part = v % 256;
                if (o == 6'h20 && part >= 128) part = part - 256;
            end
            2: begin
                part = v % 65536;
                if (o == 6'h21 && part >= 32768) part = part - 65536;
            end
            default: part = longint'(d);
        endcase
        return 32'(part);
    endfunction

    task automatic run_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] md,
                          input logic [3:0] sl, input int unsigned waits,
                          input logic [31:0] rd, input bit poke);
        bit st;
        bit mis;
        st  = is_store(o);
        mis = (a % size_of(o)) != 0;
        op = o; addr = a; mdata = md; store_loc = sl; exec = 1'b1;
        tick();
        exec = 1'b0;
        if (!is_valid(o)) begin
            chk("inv_busy", 32'(busy), 32'd0);
            chk("inv_req", 32'(bus.mem_req), 32'd0);
            chk("inv_done", 32'(done), 32'd0);
            return;
        end
        if (mis || (st && sl == 4'b0000)) begin
            if (mis) model_rdata = '0;
            if (poke) begin op = 6'h23; addr = 32'h0; exec = 1'b1; end
            chk("flt_done", 32'(done), 32'd1);
            chk("flt_misalign", 32'(misalign), 32'(mis));
            chk("flt_req", 32'(bus.mem_req), 32'd0);
            chk("flt_busy", 32'(busy), 32'd1);
            chk("flt_rdata", rdata, model_rdata);
            tick();
            exec = 1'b0;
            chk("flt_end_done", 32'(done), 32'd0);
            chk("flt_end_busy", 32'(busy), 32'd0);
            chk("flt_end_req", 32'(bus.mem_req), 32'd0);
            return;
        end
        chk("req_up", 32'(bus.mem_req), 32'd1);
        chk("req_busy", 32'(busy), 32'd1);
        chk("req_we", 32'(bus.mem_we), 32'(st));
        chk("req_addr", 32'(bus.mem_addr), a >> 2);
        chk("req_be", 32'(bus.mem_be), st ? 32'(sl) : 32'hF);
        if (st) chk("req_wdata", bus.mem_wdata, md);
        if (poke) begin op = 6'h23; addr = 32'h0; exec = 1'b1; end
        for (int unsigned i = 0; i < waits; i++) begin
            tick();
            exec = 1'b0;
            chk("wait_req", 32'(bus.mem_req), 32'd1);
            chk("wait_done", 32'(done), 32'd0);
            chk("wait_addr", 32'(bus.mem_addr), a >> 2);
        end
        bus.mem_ack = 1'b1;
        bus.mem_rdata = rd;
        tick();
        bus.mem_ack = 1'b0;
        bus.mem_rdata = $urandom();
        exec = 1'b0;
        if (!st) model_rdata = ref_load(o, a, rd);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_req", 32'(bus.mem_req), 32'd0);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_misalign", 32'(misalign), 32'd0);
        chk("done_err", 32'(err), 32'd0);
        chk("done_rdata", rdata, model_rdata);
        if (poke) begin op = 6'h23; addr = 32'h0; exec = 1'b1; end
        tick();
        exec = 1'b0;
        chk("post_done", 32'(done), 32'd0);
        chk("post_busy", 32'(busy), 32'd0);
        tick();
        chk("post_req", 32'(bus.mem_req), 32'd0);
        chk("post_rdata", rdata, model_rdata);
    endtask

    initial begin
        logic [5:0] ops [10];
        ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h22, 6'h2A};
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;

        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_be", 32'(bus.mem_be), 32'd0);
        p_reset = 1'b1;
        tick();

        run_op(6'h23, 32'h100, 32'h0, 4'h0, 3, 32'hDEADBEEF, 1'b0);
        run_op(6'h20, 32'h103, 32'h0, 4'h0, 0, 32'h80FF7F01, 1'b0);
        chk("lb_value", rdata, 32'hFFFFFF80);
        run_op(6'h24, 32'h103, 32'h0, 4'h0, 0, 32'h80FF7F01, 1'b0);
        chk("lbu_value", rdata, 32'h00000080);
        run_op(6'h29, 32'h202, 32'hABCD0000, 4'b1100, 1, 32'h12345678, 1'b1);
        chk("sh_keeps_rdata", rdata, 32'h00000080);
        run_op(6'h23, 32'h101, 32'h0, 4'h0, 0, 32'h0, 1'b1);
        run_op(6'h29, 32'h203, 32'h0, 4'b1100, 0, 32'h0, 1'b1);
        run_op(6'h21, 32'h10, 32'h0, 4'h0, 2, 32'h8001_7FFF, 1'b0);
        run_op(6'h2B, 32'h40, 32'h55AA55AA, 4'b0000, 0, 32'h0, 1'b0);

        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("stray_ack_busy", 32'(busy), 32'd0);
        chk("stray_ack_done", 32'(done), 32'd0);

        op = 6'h23; addr = 32'h300; exec = 1'b1;
        tick();
        exec = 1'b0;
        chk("rstmid_req", 32'(bus.mem_req), 32'd1);
        tick();
        p_reset = 1'b0;
        tick();
        model_rdata = '0;
        chk("rstmid_req_drop", 32'(bus.mem_req), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_we", 32'(bus.mem_we), 32'd0);
        chk("rstmid_addr", 32'(bus.mem_addr), 32'd0);
        chk("rstmid_wdata", bus.mem_wdata, 32'd0);
        chk("rstmid_rdata", rdata, 32'd0);
        p_reset = 1'b1;
        tick();
        run_op(6'h23, 32'h304, 32'h0, 4'h0, 1, 32'hCAFEF00D, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic [5:0]  o;
            logic [31:0] a;
            logic [3:0]  sl;
            o  = ops[$urandom_range(0, 9)];
            a  = $urandom();
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            sl = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom());
            run_op(o, a, $urandom(), sl, $urandom_range(0, 3), $urandom(), n[0]);
        end

        op = 6'h23; addr = 32'h400; exec = 1'b1;
        tick();
        exec = 1'b0;
`ifdef P32_MEM_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            chk("tmo_req", 32'(bus.mem_req), 32'd1);
            chk("tmo_nodone", 32'(done), 32'd0);
            tick();
        end
        chk("tmo_req_drop", 32'(bus.mem_req), 32'd0);
        chk("tmo_done", 32'(done), 32'd1);
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_rdata", rdata, model_rdata);
        tick();
        chk("tmo_end_done", 32'(done), 32'd0);
        chk("tmo_end_err", 32'(err), 32'd0);
        chk("tmo_end_busy", 32'(busy), 32'd0);
`else
        for (int i = 0; i < 20; i++) begin
            chk("hang_req", 32'(bus.mem_req), 32'd1);
            chk("hang_done", 32'(done), 32'd0);
            chk("hang_err", 32'(err), 32'd0);
            tick();
        end
        p_reset = 1'b0;
        tick();
        chk("hang_rst_req", 32'(bus.mem_req), 32'd0);
        p_reset = 1'b1;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
